// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle for one modulo counter stage.
//   en        count enable (master -> counter)
//   up_dn     direction, 1 = up, 0 = down (master -> counter)
//   clr       synchronous clear to 0 (master -> counter)
//   load      synchronous load of load_val (master -> counter)
//   load_val  value captured on load (master -> counter)
//   num_out   registered current count (counter -> master)
//   ci        registered one-cycle wrap pulse (counter -> master)
//   tc        combinational terminal-count flag for cascading (counter -> master)
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] num_out;
  logic             ci;
  logic             tc;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  num_out, ci, tc
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output num_out, ci, tc
  );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo-MODULUS counter with synchronous clear and
// saturating load, a registered wrap pulse and a combinational terminal-count
// flag so several stages can be cascaded without ripple latency.
//   clk        rising-edge clock
//   sys_rst_n  asynchronous active-low reset (count and wrap pulse to 0)
//   bus        mod_counter_if slave modport:
//                en/up_dn/clr/load/load_val in, num_out/ci/tc out
// Per-edge priority is clr > load > en. Legal MODULUS is 2..2**WIDTH.
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  mod_counter_if.slave  bus
);

  // Parameter sanity is enforced at elaboration so an illegal modulus can
  // never produce an out-of-range count.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ci_q, ci_d;

  // Next-state selection. The wrap pulse defaults low so it only survives
  // one cycle; a wrap is always judged against up_dn at this very edge.
  // Loads above the top value saturate, so no reachable count exceeds MaxVal.
  always_comb begin
    count_d = count_q;
    ci_d    = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (count_q == MaxVal) begin
          count_d = '0;
          ci_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MaxVal;
          ci_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset acts immediately, independent of the clock.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_q <= '0;
      ci_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ci_q    <= ci_d;
    end
  end

  assign bus.num_out = count_q;
  assign bus.ci      = ci_q;

  // Terminal count looks only at direction and the current count, so a
  // higher stage enabled by (en & tc) steps on the same edge as this one.
  assign bus.tc = bus.up_dn ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: randomized scoreboard bench for mod_counter.
// Three stages share the same stimulus (MODULUS 10, 6, and 8 with WIDTH 3);
// a pair of decimal stages is cascaded through tc for the 00..99 check.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       sysRstN;
  logic       en, upDn, clr, load;
  logic [3:0] loadVal;
  logic       casEn, casClr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) bus0 ();
  mod_counter_if #(.WIDTH(4)) bus1 ();
  mod_counter_if #(.WIDTH(3)) bus2 ();
  mod_counter_if #(.WIDTH(4)) casLo ();
  mod_counter_if #(.WIDTH(4)) casHi ();

  assign bus0.en = en;   assign bus0.up_dn = upDn; assign bus0.clr = clr;
  assign bus0.load = load; assign bus0.load_val = loadVal;
  assign bus1.en = en;   assign bus1.up_dn = upDn; assign bus1.clr = clr;
  assign bus1.load = load; assign bus1.load_val = loadVal;
  assign bus2.en = en;   assign bus2.up_dn = upDn; assign bus2.clr = clr;
  assign bus2.load = load; assign bus2.load_val = loadVal[2:0];

  assign casLo.en = casEn;              assign casLo.up_dn = 1'b1;
  assign casLo.clr = casClr;            assign casLo.load = 1'b0;
  assign casLo.load_val = 4'd0;
  assign casHi.en = casEn & casLo.tc;   assign casHi.up_dn = 1'b1;
  assign casHi.clr = casClr;            assign casHi.load = 1'b0;
  assign casHi.load_val = 4'd0;

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut0 (.clk(clk), .sys_rst_n(sysRstN), .bus(bus0));
  mod_counter #(.WIDTH(4), .MODULUS(6))  dut1 (.clk(clk), .sys_rst_n(sysRstN), .bus(bus1));
  mod_counter #(.WIDTH(3), .MODULUS(8))  dut2 (.clk(clk), .sys_rst_n(sysRstN), .bus(bus2));
  mod_counter #(.WIDTH(4), .MODULUS(10)) dutLo (.clk(clk), .sys_rst_n(sysRstN), .bus(casLo));
  mod_counter #(.WIDTH(4), .MODULUS(10)) dutHi (.clk(clk), .sys_rst_n(sysRstN), .bus(casHi));

  typedef struct {
    int n0; bit c0; bit t0;
    int n1; bit c1; bit t1;
    int n2; bit c2; bit t2;
  } exp_t;

  exp_t sb[$];
  int   cnt0 = 0, cnt1 = 0, cnt2 = 0;

  // Reference rules: modular arithmetic on plain integers.
  function automatic int nextCount(input int cnt, input int m, input bit e, input bit up,
                                   input bit c, input bit l, input int lv, output bit wrap);
    wrap = 1'b0;
    if (c) return 0;
    if (l) return (lv > m - 1) ? m - 1 : lv;
    if (!e) return cnt;
    if (up) begin
      wrap = (cnt == m - 1);
      return (cnt + 1) % m;
    end
    wrap = (cnt == 0);
    return (cnt + m - 1) % m;
  endfunction

  function automatic bit tcOf(input int cnt, input int m, input bit up);
    return up ? (cnt == m - 1) : (cnt == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // mode 0: normal edge, mode 1: reset pulse between edges, mode 2: reset held across the edge.
  task automatic applyStimulus(input int mode, input bit e, input bit up, input bit c,
                               input bit l, input logic [3:0] lv);
    exp_t x;
    @(negedge clk);
    if (mode == 1) begin
      sysRstN = 1'b0;
      #1;
      checkOutput("rstPulseNum", 32'(bus0.num_out), 0);
      checkOutput("rstPulseCi", 32'(bus0.ci), 0);
      #1 sysRstN = 1'b1;
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
    end else if (mode == 2) begin
      sysRstN = 1'b0;
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
    end else begin
      sysRstN = 1'b1;
    end
    en = e; upDn = up; clr = c; load = l; loadVal = lv;
    #1;
    checkOutput("tcComb", 32'(bus0.tc), 32'(tcOf(cnt0, 10, up)));
    if (mode == 2) begin
      checkOutput("rstHoldNum", 32'(bus0.num_out), 0);
      checkOutput("rstHoldCi", 32'(bus0.ci), 0);
      x.c0 = 1'b0; x.c1 = 1'b0; x.c2 = 1'b0;
    end else begin
      cnt0 = nextCount(cnt0, 10, e, up, c, l, int'(lv), x.c0);
      cnt1 = nextCount(cnt1, 6, e, up, c, l, int'(lv), x.c1);
      cnt2 = nextCount(cnt2, 8, e, up, c, l, int'(lv[2:0]), x.c2);
    end
    x.n0 = cnt0; x.t0 = tcOf(cnt0, 10, up);
    x.n1 = cnt1; x.t1 = tcOf(cnt1, 6, up);
    x.n2 = cnt2; x.t2 = tcOf(cnt2, 8, up);
    sb.push_back(x);
  endtask

  // Monitor: every edge that has an outstanding expectation is checked.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checkOutput("num10", 32'(bus0.num_out), 32'(x.n0));
        checkOutput("ci10", 32'(bus0.ci), 32'(x.c0));
        checkOutput("tc10", 32'(bus0.tc), 32'(x.t0));
        checkOutput("num6", 32'(bus1.num_out), 32'(x.n1));
        checkOutput("ci6", 32'(bus1.ci), 32'(x.c1));
        checkOutput("tc6", 32'(bus1.tc), 32'(x.t1));
        checkOutput("num8", 32'(bus2.num_out), 32'(x.n2));
        checkOutput("ci8", 32'(bus2.ci), 32'(x.c2));
        checkOutput("tc8", 32'(bus2.tc), 32'(x.t2));
      end
    end
  end

  initial begin
    sysRstN = 1'b0;
    en = 1'b0; upDn = 1'b1; clr = 1'b0; load = 1'b0; loadVal = 4'd0;
    casEn = 1'b0; casClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetNum", 32'(bus0.num_out), 0);
    checkOutput("resetCi", 32'(bus0.ci), 0);
    checkOutput("resetTc", 32'(bus0.tc), 0);

    // Count up from reset across the 9->0 wrap.
    for (int i = 0; i < 12; i++) applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    // Loads in range and saturating, then clear winning over load.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    // Count down from 0 to wrap every stage.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    // Direction change at the top value.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    // Reset pulse while sitting at 9 with en high.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    // Reset pulse during a wrap-pulse cycle.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    // Reset held across an enabled edge.
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);

    for (int i = 0; i < 400; i++) begin
      int r;
      int mode;
      r = int'($urandom_range(0, 99));
      mode = (r < 2) ? 1 : ((r < 4) ? 2 : 0);
      applyStimulus(mode, ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end

    // Two decimal stages cascaded through tc: 00..99 then 00.
    @(negedge clk);
    sysRstN = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
    casClr = 1'b1;
    @(negedge clk);
    casClr = 1'b0; casEn = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      checkOutput("cascade", 32'(casHi.num_out) * 10 + 32'(casLo.num_out), 32'(i % 100));
      checkOutput("cascadeCi", 32'(casHi.ci), 32'(i == 100));
    end
    casEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, is the counter and load-value width in bits.
REQ-002 Parameter MODULUS, default 10, is the count range 0..MODULUS-1; legal range is 2 <= MODULUS <= 2^WIDTH.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port sys_rst_n  input  1  is an asynchronous, active-low reset.
REQ-005 Port en  input  1  is the count enable; a count step occurs only on an edge with en=1.
REQ-006 Port up_dn  input  1  selects direction: 1 counts up, 0 counts down.
REQ-007 Port clr  input  1  is a synchronous clear to 0.
REQ-008 Port load  input  1  is a synchronous load of load_val.
REQ-009 Port load_val  input  WIDTH  is the value captured when load=1.
REQ-010 Port num_out  output  WIDTH  is the registered current count.
REQ-011 Port ci  output  1  is the registered wrap pulse (carry up, borrow down).
REQ-012 Port tc  output  1  is the combinational terminal-count flag for cascading.

Function
REQ-013 Per-edge priority SHALL be clr > load > en; with none of them asserted, num_out and ci SHALL hold and be cleared to 0, respectively.
REQ-014 clr=1 SHALL set num_out=0 and ci=0 on that edge, regardless of load, en and up_dn.
REQ-015 load=1 (clr=0) SHALL set num_out=load_val if load_val <= MODULUS-1, else num_out=MODULUS-1 (saturate); ci=0.
REQ-016 Counting up (en=1, up_dn=1): num_out < MODULUS-1 increments by 1 with ci=0; num_out = MODULUS-1 wraps to 0 with ci=1.
REQ-017 Counting down (en=1, up_dn=0): num_out > 0 decrements by 1 with ci=0; num_out = 0 wraps to MODULUS-1 with ci=1.
REQ-018 ci SHALL be high for exactly the one cycle following the wrapping edge, i.e. coincident with the post-wrap value on num_out; it SHALL be 0 on every other cycle.
REQ-019 ci SHALL be 0 on any edge where en=0, clr=1 or load=1.
REQ-020 tc SHALL equal 1 when (up_dn=1 and num_out=MODULUS-1) or (up_dn=0 and num_out=0), else 0; it SHALL not depend on en, clr or load.
REQ-021 Cascading SHALL work with a higher stage's en driven by (lower en AND lower tc), so that all stages step on the same edge with no ripple latency.
REQ-022 A direction change SHALL take effect on the next enabled edge with no extra latency; a wrap is always judged against the up_dn value at that edge.
REQ-023 num_out SHALL never hold a value >= MODULUS in any reachable state.
REQ-024 Arithmetic SHALL be WIDTH bits with no overflow beyond the wrap rules; MODULUS = 2^WIDTH SHALL wrap identically to the natural rollover.
REQ-025 Latency from a qualifying edge to the num_out/ci update SHALL be zero additional cycles (registered outputs valid after that edge).

Reset
REQ-026 sys_rst_n=0 SHALL immediately force num_out=0 and ci=0, independent of clk, including mid-count or during a wrap cycle.
REQ-027 While sys_rst_n=0, all inputs SHALL be ignored; tc follows REQ-020 from num_out=0.
REQ-028 After deassertion, the first rising clk edge SHALL behave per REQ-013..REQ-017 from num_out=0.

Verification
REQ-029 Defaults, en=1, up_dn=1, 12 edges from reset -> num_out 1..9,0,1,2; ci=1 only in the cycle num_out=0 after the 9->0 wrap; tc=1 only while num_out=9.
REQ-030 MODULUS=6, en=1, up_dn=0 from reset -> num_out 5,4,3,2,1,0,5; ci=1 on the first 5 and the second 5; tc=1 while num_out=0.
REQ-031 Defaults, load=1 load_val=7, then load_val=13 -> num_out=7, then num_out=9; ci=0 throughout; with clr=1 and load=1 together -> num_out=0.
REQ-032 Two defaults cascaded per REQ-021, 100 enabled edges -> {high,low} counts 00..99 then 00; high ci pulses once, on the 99->00 edge.
REQ-033 sys_rst_n pulsed low between clock edges while num_out=9 and en=1 -> num_out=0 and ci=0 immediately; no ci pulse appears after release.
REQ-034 up_dn toggled from 1 to 0 at num_out=9 with en=1 -> next value 8, ci=0; tc changes from 1 to 0 combinationally with up_dn.
